enc_8b_rr: RTL and testbench

ENC_8B_RR -- requirements
Module: enc_8b_rr

---
 rtl/enc_8b_rr_if.sv | 33 +++
 rtl/enc_8b_rr.sv | 113 +++++++++++
 tb/tb_enc_8b_rr.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/enc_8b_rr_if.sv
// rtl/enc_8b_rr_if.sv - request mask in, granted index stream out
`timescale 1ns/1ps
interface enc_8b_rr_if;
  logic [7:0] req_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [2:0] idx_o;
  logic       idx_valid_o;
  logic       idx_last_o;
  logic       idx_ready_i;

  // Encoder side: consumes masks, produces indices
  modport slave (
    input  req_i,
    input  req_valid_i,
    output req_ready_o,
    output idx_o,
    output idx_valid_o,
    output idx_last_o,
    input  idx_ready_i
  );

  // Driver side: produces masks, consumes indices
  modport master (
    output req_i,
    output req_valid_i,
    input  req_ready_o,
    input  idx_o,
    input  idx_valid_o,
    input  idx_last_o,
    output idx_ready_i
  );
endinterface

// File: rtl/enc_8b_rr.sv
// rtl/enc_8b_rr.sv - round-robin mask-to-index stream encoder
`timescale 1ns/1ps
module enc_8b_rr (
  input  logic        clk_i,
  input  logic        rst_i,
  enc_8b_rr_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic       idx_valid_q, idx_valid_d;
  logic       idx_last_q, idx_last_d;

  logic       handshake;
  logic [2:0] ptr_next;
  logic [7:0] pending_clr;

  // First set bit of m scanning upward from p, wrapping 7 -> 0
  function automatic logic [2:0] first_from(input logic [7:0] m, input logic [2:0] p);
    logic       found;
    logic [2:0] j;
    first_from = p;
    found      = 1'b0;
    for (int i = 0; i < 8; i++) begin
      j = p + i[2:0];
      if (!found && m[j]) begin
        first_from = j;
        found      = 1'b1;
      end
    end
  endfunction

  // True when exactly one bit of m is set
  function automatic logic single_bit(input logic [7:0] m);
    single_bit = (m != 8'h00) && ((m & (m - 8'h01)) == 8'h00);
  endfunction

  assign handshake   = idx_valid_q && bus.idx_ready_i;
  assign ptr_next    = idx_q + 3'd1;
  assign pending_clr = pending_q & ~(8'h01 << idx_q);

  // Next-state: load a mask in IDLE, retire one index per handshake in BUSY
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    idx_valid_d = idx_valid_q;
    idx_last_d  = idx_last_q;
    case (state_q)
      IDLE: begin
        // Zero masks are swallowed here without leaving IDLE
        if (bus.req_valid_i && (bus.req_i != 8'h00)) begin
          state_d     = BUSY;
          pending_d   = bus.req_i;
          idx_d       = first_from(bus.req_i, ptr_q);
          idx_valid_d = 1'b1;
          idx_last_d  = single_bit(bus.req_i);
        end
      end
      BUSY: begin
        if (handshake) begin
          pending_d = pending_clr;
          ptr_d     = ptr_next;
          if (idx_last_q) begin
            state_d     = IDLE;
            idx_valid_d = 1'b0;
            idx_last_d  = 1'b0;
          end else begin
            // Next index is ready in the same cycle, so beats stay back-to-back
            idx_d      = first_from(pending_clr, ptr_next);
            idx_last_d = single_bit(pending_clr);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pending_q   <= 8'h00;
      ptr_q       <= 3'd0;
      idx_q       <= 3'd0;
      idx_valid_q <= 1'b0;
      idx_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      idx_last_q  <= idx_last_d;
    end
  end

  assign bus.req_ready_o = (state_q == IDLE) && !rst_i;
  assign bus.idx_o       = idx_q;
  assign bus.idx_valid_o = idx_valid_q;
  assign bus.idx_last_o  = idx_last_q;

endmodule

// File: tb/tb_enc_8b_rr.sv
// tb/tb_enc_8b_rr.sv - scoreboard bench for enc_8b_rr
`timescale 1ns/1ps
module tb_enc_8b_rr;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [3:0] exp_q[$];

  enc_8b_rr_if bus ();

  enc_8b_rr dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input logic [2:0] idx, input logic last);
    exp_q.push_back({last, idx});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (!bus.req_ready_o && t < 200) begin
      tick();
      t++;
    end
    if (!bus.req_ready_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: req_ready_o timeout got 0 expected 1", name);
    end
  endtask

  task automatic send_mask(input logic [7:0] m);
    wait_ready("send_wait");
    bus.req_i       = m;
    bus.req_valid_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    bus.req_i       = 8'h3C;
  endtask

  // Monitor: every handshake pops one expected beat
  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst && bus.idx_valid_o && bus.idx_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got idx %0d last %0d expected none", bus.idx_o, bus.idx_last_o);
      end else begin
        e = exp_q.pop_front();
        chk("beat_idx", bus.idx_o, e[2:0]);
        chk("beat_last", bus.idx_last_o, e[3]);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req_i = 8'h00;
    bus.req_valid_i = 1'b0;
    bus.idx_ready_i = 1'b1;
    repeat (3) tick();
    chk("rst_req_ready", bus.req_ready_o, 0);
    chk("rst_idx_valid", bus.idx_valid_o, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", bus.req_ready_o, 1);
    chk("post_rst_idx", bus.idx_o, 0);
    chk("post_rst_last", bus.idx_last_o, 0);

    // Single-bit mask
    push_beat(3'd0, 1'b1);
    send_mask(8'h01);
    chk("m01_valid", bus.idx_valid_o, 1);
    chk("m01_idx", bus.idx_o, 0);
    chk("m01_last", bus.idx_last_o, 1);
    tick();
    chk("m01_idle_ready", bus.req_ready_o, 1);
    chk("m01_idle_valid", bus.idx_valid_o, 0);

    // Reset to bring ptr back to 0, then A5 with no bubbles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_beat(3'd0, 1'b0);
    push_beat(3'd2, 1'b0);
    push_beat(3'd5, 1'b0);
    push_beat(3'd7, 1'b1);
    send_mask(8'hA5);
    for (int k = 0; k < 4; k++) begin
      chk("a5_no_bubble", bus.idx_valid_o, 1);
      tick();
    end
    chk("a5_done_valid", bus.idx_valid_o, 0);
    chk("a5_done_ready", bus.req_ready_o, 1);

    // Wrap: ptr 0 -> 4 after 08, then 11 gives 4 then 0
    push_beat(3'd3, 1'b1);
    send_mask(8'h08);
    wait_ready("m08");
    push_beat(3'd4, 1'b0);
    push_beat(3'd0, 1'b1);
    send_mask(8'h11);
    wait_ready("m11");

    // Zero mask: no beat, stays idle, ptr stays 1
    send_mask(8'h00);
    for (int k = 0; k < 3; k++) begin
      chk("zero_valid", bus.idx_valid_o, 0);
      chk("zero_ready", bus.req_ready_o, 1);
      tick();
    end

    // Backpressure mid-stream: 66 from ptr 1 -> 1,2,5,6
    bus.idx_ready_i = 1'b0;
    push_beat(3'd1, 1'b0);
    push_beat(3'd2, 1'b0);
    push_beat(3'd5, 1'b0);
    push_beat(3'd6, 1'b1);
    send_mask(8'h66);
    chk("bp_first_idx", bus.idx_o, 1);
    bus.idx_ready_i = 1'b1;
    tick();
    bus.idx_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_idx", bus.idx_o, 2);
      chk("bp_hold_valid", bus.idx_valid_o, 1);
      chk("bp_hold_last", bus.idx_last_o, 0);
      chk("bp_busy_ready", bus.req_ready_o, 0);
      tick();
    end
    bus.idx_ready_i = 1'b1;
    wait_ready("m66");

    // Reset during BUSY of FF (ptr 7), stalled so no beats leave
    bus.idx_ready_i = 1'b0;
    send_mask(8'hFF);
    chk("ff_idx", bus.idx_o, 7);
    chk("ff_valid", bus.idx_valid_o, 1);
    rst = 1'b1;
    tick();
    chk("ff_rst_valid", bus.idx_valid_o, 0);
    chk("ff_rst_ready", bus.req_ready_o, 0);
    rst = 1'b0;
    #1;
    chk("ff_release_ready", bus.req_ready_o, 1);
    bus.idx_ready_i = 1'b1;
    push_beat(3'd7, 1'b1);
    send_mask(8'h80);
    chk("m80_last", bus.idx_last_o, 1);
    wait_ready("m80");
    push_beat(3'd0, 1'b0);
    push_beat(3'd7, 1'b1);
    send_mask(8'h81);
    wait_ready("m81");
    repeat (3) tick();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
